// File: rtl/spikecnt_sched_if.sv
// Snapshot reader port of spikecnt_sched.
// master drives words out and slave accepts them.
interface spikecnt_sched_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic             rd_valid;
   logic             rd_ready;
   logic [CH_W-1:0]  rd_ch;
   logic [CNT_W-1:0] rd_data;

   modport master (
      output rd_valid,
      output rd_ch,
      output rd_data,
      input  rd_ready
   );

   modport slave (
      input  rd_valid,
      input  rd_ch,
      input  rd_data,
      output rd_ready
   );
endinterface

// File: rtl/spikecnt_sched.sv
// Multi-channel spike counter with slow_clk-delimited windows and serial readout.
// Define SPIKECNT_SCHED_SAT_EN for saturating counters; otherwise they wrap.
module spikecnt_sched #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic              fast_clk,
   input  logic              reset,
   input  logic              slow_clk,
   input  logic [NUM_CH-1:0] spike,
   spikecnt_sched_if.master  rd,
   output logic              frame_start,
   output logic              busy,
   output logic              overrun
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SNAP = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;

   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
   localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef SPIKECNT_SCHED_SAT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
`endif

   logic [SYNC_STAGES-1:0] tk_sync_q, tk_sync_d;
   logic                   tk_prev_q, tk_prev_d;
   logic [NUM_CH-1:0]      sp_sync_q [SYNC_STAGES];
   logic [NUM_CH-1:0]      sp_sync_d [SYNC_STAGES];
   logic [NUM_CH-1:0]      sp_prev_q, sp_prev_d;

   logic [1:0]       state_q, state_d;
   logic [CH_W-1:0]  rd_ch_q, rd_ch_d;
   logic             tick_pend_q, tick_pend_d;
   logic             overrun_q, overrun_d;
   logic [CNT_W-1:0] cnt_q [NUM_CH];
   logic [CNT_W-1:0] cnt_d [NUM_CH];
   logic [CNT_W-1:0] snap_q [NUM_CH];
   logic [CNT_W-1:0] snap_d [NUM_CH];

   logic              tick;
   logic [NUM_CH-1:0] sp_edge;

   always_comb begin
      tk_sync_d    = {tk_sync_q[SYNC_STAGES-2:0], slow_clk};
      tk_prev_d    = tk_sync_q[SYNC_STAGES-1];
      sp_sync_d[0] = spike;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sp_sync_d[s] = sp_sync_q[s-1];
      end
      sp_prev_d = sp_sync_q[SYNC_STAGES-1];
   end

   assign tick    = tk_sync_q[SYNC_STAGES-1] & ~tk_prev_q;
   assign sp_edge = sp_sync_q[SYNC_STAGES-1] & ~sp_prev_q;

   // The SNAP cycle swaps windows: a coincident edge seeds the new window.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         snap_d[i] = snap_q[i];
         cnt_d[i]  = cnt_q[i];
         if (state_q == S_SNAP) begin
            snap_d[i] = cnt_q[i];
            cnt_d[i]  = sp_edge[i] ? CNT_ONE : '0;
         end else if (sp_edge[i]) begin
`ifdef SPIKECNT_SCHED_SAT_EN
            if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_ONE;
`else
            cnt_d[i] = cnt_q[i] + CNT_ONE;
`endif
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_ch_d     = rd_ch_q;
      tick_pend_d = tick_pend_q;
      overrun_d   = overrun_q;
      unique case (1'b1)
         (state_q == S_IDLE): begin
            if (tick) state_d = S_SNAP;
         end
         (state_q == S_SNAP): begin
            state_d     = S_SEND;
            rd_ch_d     = '0;
            tick_pend_d = 1'b0;
         end
         (state_q == S_SEND): begin
            if (tick) begin
               tick_pend_d = 1'b1;
               overrun_d   = 1'b1;
            end
            if (rd.rd_ready) begin
               if (rd_ch_q == LAST_CH) begin
                  state_d = (tick_pend_q | tick) ? S_SNAP : S_IDLE;
               end else begin
                  rd_ch_d = rd_ch_q + CH_ONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge fast_clk) begin
      if (reset) begin
         tk_sync_q   <= '0;
         tk_prev_q   <= 1'b0;
         sp_prev_q   <= '0;
         state_q     <= S_IDLE;
         rd_ch_q     <= '0;
         tick_pend_q <= 1'b0;
         overrun_q   <= 1'b0;
         for (int s = 0; s < SYNC_STAGES; s++) sp_sync_q[s] <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]  <= '0;
            snap_q[i] <= '0;
         end
      end else begin
         tk_sync_q   <= tk_sync_d;
         tk_prev_q   <= tk_prev_d;
         sp_prev_q   <= sp_prev_d;
         state_q     <= state_d;
         rd_ch_q     <= rd_ch_d;
         tick_pend_q <= tick_pend_d;
         overrun_q   <= overrun_d;
         for (int s = 0; s < SYNC_STAGES; s++) sp_sync_q[s] <= sp_sync_d[s];
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]  <= cnt_d[i];
            snap_q[i] <= snap_d[i];
         end
      end
   end

   assign rd.rd_valid = (state_q == S_SEND);
   assign rd.rd_ch    = rd_ch_q;
   assign rd.rd_data  = snap_q[rd_ch_q];
   assign frame_start = (state_q == S_SNAP);
   assign busy        = (state_q == S_SEND);
   assign overrun     = overrun_q;
endmodule

// File: tb/tb_spikecnt_sched.sv
// Directed bench for spikecnt_sched with a scoreboard of expected snapshot words.
// A second 4-bit instance covers counter overflow.
module tb_spikecnt_sched;
   typedef struct {
      logic [1:0]  ch;
      logic [31:0] data;
   } word_t;

   logic       fast_clk = 1'b0;
   logic       reset;
   logic       slow_clk;
   logic [3:0] spike;
   logic       frame_start, busy, overrun;
   logic       fs2, busy2, ovr2;

   spikecnt_sched_if #(.NUM_CH(4), .CNT_W(32)) rd1 ();
   spikecnt_sched_if #(.NUM_CH(4), .CNT_W(4))  rd2 ();

   spikecnt_sched #(.NUM_CH(4), .CNT_W(32), .SYNC_STAGES(2)) dut (
      .fast_clk(fast_clk), .reset(reset), .slow_clk(slow_clk),
      .spike(spike), .rd(rd1), .frame_start(frame_start),
      .busy(busy), .overrun(overrun)
   );

   spikecnt_sched #(.NUM_CH(4), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
      .fast_clk(fast_clk), .reset(reset), .slow_clk(slow_clk),
      .spike(spike), .rd(rd2), .frame_start(fs2),
      .busy(busy2), .overrun(ovr2)
   );

   always #5 fast_clk = ~fast_clk;

   int    n_chk = 0;
   int    n_fail = 0;
   int    busy_tot = 0;
   int    fs_tot = 0;
   int    exp_cnt [4];
   word_t sb_q [$];

`ifdef SPIKECNT_SCHED_SAT_EN
   localparam logic [31:0] EXP_OVF = 32'd15;
`else
   localparam logic [31:0] EXP_OVF = 32'd4;
`endif

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge fast_clk) begin
      if (reset) begin
         sb_q.delete();
      end else begin
         if (busy) busy_tot++;
         if (frame_start) fs_tot++;
         if (rd1.rd_valid && rd1.rd_ready) begin
            n_chk++;
            assert (sb_q.size() != 0) else begin
               n_fail++;
               $error("FAIL sb_unexpected observed ch=%0d data=%0h expected none",
                      rd1.rd_ch, rd1.rd_data);
            end
            if (sb_q.size() != 0) begin
               word_t w;
               w = sb_q.pop_front();
               check("sb_ch", 64'(rd1.rd_ch), 64'(w.ch));
               check("sb_data", 64'(rd1.rd_data), 64'(w.data));
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge fast_clk);
         #1;
      end
   endtask

   task automatic pulse(input int ch, input int n);
      repeat (n) begin
         spike[ch] = 1'b1;
         step(2);
         spike[ch] = 1'b0;
         step(2);
         exp_cnt[ch]++;
      end
   endtask

   task automatic push_frame();
      for (int i = 0; i < 4; i++) begin
         word_t w;
         w.ch   = 2'(i);
         w.data = 32'(exp_cnt[i]);
         sb_q.push_back(w);
         exp_cnt[i] = 0;
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
   endtask

   task automatic wait_fs(input string tag);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (frame_start) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, 64'(ok), 64'd1);
   endtask

   task automatic wait_idle(input string tag);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         step();
         if (sb_q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, 64'(ok), 64'd1);
   endtask

   initial begin
      int b0;
      int f0;
      clear_model();
      reset        = 1'b1;
      slow_clk     = 1'b0;
      spike        = '0;
      rd1.rd_ready = 1'b0;
      rd2.rd_ready = 1'b1;
      step(3);
      reset = 1'b0;
      step();
      check("rst_valid", 64'(rd1.rd_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      check("rst_fs", 64'(frame_start), 64'd0);
      check("rst_ch", 64'(rd1.rd_ch), 64'd0);
      check("rst_data", 64'(rd1.rd_data), 64'd0);

      // basic frame
      rd1.rd_ready = 1'b1;
      pulse(0, 5);
      pulse(2, 3);
      step(3);
      push_frame();
      f0 = fs_tot;
      b0 = busy_tot;
      slow_clk = 1'b1;
      wait_fs("t1_fs_seen");
      for (int i = 0; i < 4; i++) begin
         step();
         check("t1_valid", 64'(rd1.rd_valid), 64'd1);
         check("t1_ch", 64'(rd1.rd_ch), 64'(i));
      end
      step();
      check("t1_busy_fall", 64'(busy), 64'd0);
      slow_clk = 1'b0;
      step(2);
      check("t1_fs_once", 64'(fs_tot - f0), 64'd1);
      check("t1_busy_cyc", 64'(busy_tot - b0), 64'd4);

      // stall on ch1
      pulse(0, 5);
      pulse(2, 3);
      step(3);
      push_frame();
      b0 = busy_tot;
      slow_clk = 1'b1;
      wait_fs("t2_fs_seen");
      step();
      check("t2_ch0", 64'(rd1.rd_ch), 64'd0);
      step();
      rd1.rd_ready = 1'b0;
      check("t2_ch1", 64'(rd1.rd_ch), 64'd1);
      for (int k = 0; k < 4; k++) begin
         step();
         check("t2_stall_valid", 64'(rd1.rd_valid), 64'd1);
         check("t2_stall_ch", 64'(rd1.rd_ch), 64'd1);
         check("t2_stall_data", 64'(rd1.rd_data), 64'd0);
      end
      rd1.rd_ready = 1'b1;
      wait_idle("t2_done");
      check("t2_busy_cyc", 64'(busy_tot - b0), 64'd8);
      slow_clk = 1'b0;

      // spike edge coincident with SNAP
      step(4);
      push_frame();
      slow_clk = 1'b1;
      step();
      spike[3] = 1'b1;
      exp_cnt[3] = 1;
      wait_idle("t3_frame_a");
      spike[3] = 1'b0;
      slow_clk = 1'b0;
      step(4);
      push_frame();
      slow_clk = 1'b1;
      wait_idle("t3_frame_b");
      slow_clk = 1'b0;

      // ticks during a stalled SEND
      step(4);
      push_frame();
      rd1.rd_ready = 1'b0;
      f0 = fs_tot;
      slow_clk = 1'b1;
      wait_fs("t4_fs_seen");
      slow_clk = 1'b0;
      pulse(1, 2);
      check("t4_ovr_clear", 64'(overrun), 64'd0);
      slow_clk = 1'b1;
      step(4);
      check("t4_ovr_set", 64'(overrun), 64'd1);
      slow_clk = 1'b0;
      pulse(0, 1);
      slow_clk = 1'b1;
      step(4);
      pulse(3, 1);
      slow_clk = 1'b0;
      step(3);
      check("t4_still_ch0", 64'(rd1.rd_ch), 64'd0);
      push_frame();
      rd1.rd_ready = 1'b1;
      step(4);
      check("t4_back2back", 64'(frame_start), 64'd1);
      wait_idle("t4_done");
      step(10);
      check("t4_two_frames", 64'(fs_tot - f0), 64'd2);
      check("t4_ovr_sticky", 64'(overrun), 64'd1);
      check("t4_idle", 64'(busy), 64'd0);

      // reset in the middle of a frame
      pulse(1, 2);
      step(3);
      push_frame();
      slow_clk = 1'b1;
      wait_fs("t6_fs_seen");
      slow_clk = 1'b0;
      step(3);
      rd1.rd_ready = 1'b0;
      check("t6_ch2", 64'(rd1.rd_ch), 64'd2);
      pulse(0, 3);
      step(3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      clear_model();
      check("t6_valid", 64'(rd1.rd_valid), 64'd0);
      check("t6_overrun", 64'(overrun), 64'd0);
      check("t6_busy", 64'(busy), 64'd0);
      rd1.rd_ready = 1'b1;
      pulse(2, 2);
      step(3);
      push_frame();
      slow_clk = 1'b1;
      wait_idle("t6_frame");
      slow_clk = 1'b0;

      // overflow on the 4-bit instance
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      clear_model();
      step();
      pulse(0, 20);
      step(3);
      push_frame();
      slow_clk = 1'b1;
      wait_fs("t5_fs_seen");
      step();
      check("t5_valid", 64'(rd2.rd_valid), 64'd1);
      check("t5_ch", 64'(rd2.rd_ch), 64'd0);
      check("t5_ovf_data", 64'(rd2.rd_data), 64'(EXP_OVF));
      wait_idle("t5_done");
      slow_clk = 1'b0;
      step(4);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
